// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the execute-to-writeback memory stage.
package mem_stage_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } stage_state_e;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_REG_W    = 3;
   localparam int DEF_WAIT_MAX = 15;

endpackage

// File: rtl/mem_access_stage_wait_timer.sv
// Bounded wait for a data-memory acknowledge.
// Down-counter loaded with WAIT_MAX on start, decremented while enabled,
// parked at zero when disabled; expired flags the last allowed wait cycle.
module wait_timer
   import mem_stage_pkg::*;
#(
   parameter int WAIT_MAX = DEF_WAIT_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next count: load, count down toward terminal count, or park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = CNT_W'(WAIT_MAX);
      end else if (!en) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = en & (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_access_stage.sv
// Execute-to-writeback stage: forwards ALU results or runs a load/store
// against a variable-latency data memory, and resolves branch-if-zero.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a new op; ALU ops and illegal ops retire next cycle
//   BUSY  | dmem_req held; waiting for dmem_ack or the wait timer to expire
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int REG_W    = DEF_REG_W,
   parameter int WAIT_MAX = DEF_WAIT_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic [DATA_W-1:0] store_data,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              reg_write,
   input  logic              branch,
   input  logic [REG_W-1:0]  rd,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_W-1:0]  wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              branch_taken,
   output logic              bus_err
);

   stage_state_e      state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [REG_W-1:0]  lat_rd_q, lat_rd_d;
   logic              lat_rw_q, lat_rw_d;
   logic              lat_load_q, lat_load_d;
   logic [DATA_W-1:0] lat_alu_q, lat_alu_d;
   logic              wb_valid_q, wb_valid_d;
   logic              wb_we_q, wb_we_d;
   logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              br_q, br_d;
   logic              err_q, err_d;

   logic accept;
   logic timer_start;
   logic timer_en;
   logic timer_expired;

   assign in_ready = (state_q == IDLE) & ~rst;
   assign accept   = in_valid & in_ready;
   assign timer_en = (state_q == BUSY);

   wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (timer_start),
      .en      (timer_en),
      .expired (timer_expired)
   );

   // next-state, request, latch and writeback computation
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lat_rd_d    = lat_rd_q;
      lat_rw_d    = lat_rw_q;
      lat_load_d  = lat_load_q;
      lat_alu_d   = lat_alu_q;
      wb_valid_d  = 1'b0;
      wb_we_d     = wb_we_q;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      br_d        = br_q;
      err_d       = err_q;
      timer_start = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (mem_read && mem_write) begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = 1'b0;
                  wb_rd_d    = rd;
                  wb_data_d  = alu_result;
                  br_d       = 1'b0;
                  err_d      = 1'b1;
               end else if (mem_read || mem_write) begin
                  state_d     = BUSY;
                  req_d       = 1'b1;
                  we_d        = mem_write;
                  addr_d      = alu_result[ADDR_W-1:0];
                  wdata_d     = store_data;
                  lat_rd_d    = rd;
                  lat_rw_d    = reg_write;
                  lat_load_d  = mem_read;
                  lat_alu_d   = alu_result;
                  timer_start = 1'b1;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = reg_write & (rd != '0);
                  wb_rd_d    = rd;
                  wb_data_d  = alu_result;
                  br_d       = branch & alu_zero;
               end
            end
         end
         BUSY: begin
            // an ack on the final wait cycle still completes normally
            if (dmem_ack) begin
               state_d    = IDLE;
               req_d      = 1'b0;
               wb_valid_d = 1'b1;
               wb_we_d    = lat_load_q & lat_rw_q & (lat_rd_q != '0);
               wb_rd_d    = lat_rd_q;
               wb_data_d  = lat_load_q ? dmem_rdata : lat_alu_q;
               br_d       = 1'b0;
            end else if (timer_expired) begin
               state_d    = IDLE;
               req_d      = 1'b0;
               wb_valid_d = 1'b1;
               wb_we_d    = 1'b0;
               wb_rd_d    = lat_rd_q;
               wb_data_d  = lat_alu_q;
               br_d       = 1'b0;
               err_d      = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         lat_rd_q   <= '0;
         lat_rw_q   <= 1'b0;
         lat_load_q <= 1'b0;
         lat_alu_q  <= '0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         br_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         lat_rd_q   <= lat_rd_d;
         lat_rw_q   <= lat_rw_d;
         lat_load_q <= lat_load_d;
         lat_alu_q  <= lat_alu_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         br_q       <= br_d;
         err_q      <= err_d;
      end
   end

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_we        = wb_we_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign branch_taken = br_q;
   assign bus_err      = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of ALU ops plus hand-written
// load/store/timeout/illegal/reset sequences.
module tb_mem_access_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic [31:0] store_data;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        branch;
   logic [2:0]  rd;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic        wb_we;
   logic [2:0]  wb_rd;
   logic [31:0] wb_data;
   logic        branch_taken;
   logic        bus_err;

   int pass_cnt  = 0;
   int total_cnt = 0;

   mem_access_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .store_data   (store_data),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .reg_write    (reg_write),
      .branch       (branch),
      .rd           (rd),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ack     (dmem_ack),
      .wb_valid     (wb_valid),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .branch_taken (branch_taken),
      .bus_err      (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu;
      logic        zero;
      logic        rw;
      logic        br;
      logic [2:0]  rd;
      logic        exp_we;
      logic [31:0] exp_data;
      logic        exp_taken;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid   = 1'b0;
      alu_result = '0;
      alu_zero   = 1'b0;
      store_data = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      branch     = 1'b0;
      rd         = '0;
      dmem_rdata = '0;
      dmem_ack   = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},   {31'd0, dmem_req},     32'd0);
      check({tag, "_we"},    {31'd0, dmem_we},      32'd0);
      check({tag, "_addr"},  {16'd0, dmem_addr},    32'd0);
      check({tag, "_wdata"}, dmem_wdata,            32'd0);
      check({tag, "_wbv"},   {31'd0, wb_valid},     32'd0);
      check({tag, "_wbwe"},  {31'd0, wb_we},        32'd0);
      check({tag, "_wbrd"},  {29'd0, wb_rd},        32'd0);
      check({tag, "_wbd"},   wb_data,               32'd0);
      check({tag, "_br"},    {31'd0, branch_taken}, 32'd0);
      check({tag, "_err"},   {31'd0, bus_err},      32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      vecs[0] = '{32'h0000_1234, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 32'h0000_1234, 1'b0};
      vecs[1] = '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 32'h0000_0000, 1'b1};
      vecs[2] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 32'hFFFF_FFFF, 1'b0};
      vecs[3] = '{32'h0000_0077, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0000_0077, 1'b0};
      vecs[4] = '{32'h8000_0000, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 32'h8000_0000, 1'b0};

      clear_inputs();
      rst = 1'b1;
      step();
      step();
      check_all_zero("reset");
      check("reset_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

      // back-to-back ALU ops, one writeback per cycle
      for (int i = 0; i < 5; i++) begin
         in_valid   = 1'b1;
         alu_result = vecs[i].alu;
         alu_zero   = vecs[i].zero;
         reg_write  = vecs[i].rw;
         branch     = vecs[i].br;
         rd         = vecs[i].rd;
         step();
         check($sformatf("alu%0d_wbv", i),   {31'd0, wb_valid},     32'd1);
         check($sformatf("alu%0d_we", i),    {31'd0, wb_we},        {31'd0, vecs[i].exp_we});
         check($sformatf("alu%0d_rd", i),    {29'd0, wb_rd},        {29'd0, vecs[i].rd});
         check($sformatf("alu%0d_data", i),  wb_data,               vecs[i].exp_data);
         check($sformatf("alu%0d_taken", i), {31'd0, branch_taken}, {31'd0, vecs[i].exp_taken});
         check($sformatf("alu%0d_req", i),   {31'd0, dmem_req},     32'd0);
      end
      clear_inputs();
      step();
      check("alu_pulse_end", {31'd0, wb_valid}, 32'd0);

      // ack while idle must be ignored
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      check("idle_ack_wbv", {31'd0, wb_valid}, 32'd0);

      // load, ack in third request cycle
      in_valid   = 1'b1;
      mem_read   = 1'b1;
      reg_write  = 1'b1;
      rd         = 3'd2;
      alu_result = 32'hABCD_0040;
      step();
      clear_inputs();
      for (int k = 1; k <= 3; k++) begin
         check($sformatf("ld_req_c%0d", k),   {31'd0, dmem_req}, 32'd1);
         check($sformatf("ld_ready_c%0d", k), {31'd0, in_ready}, 32'd0);
         check($sformatf("ld_wbv_c%0d", k),   {31'd0, wb_valid}, 32'd0);
         if (k == 1) begin
            check("ld_addr", {16'd0, dmem_addr}, 32'h0000_0040);
            check("ld_we",   {31'd0, dmem_we},   32'd0);
         end
         if (k == 3) begin
            dmem_ack   = 1'b1;
            dmem_rdata = 32'hDEAD_BEEF;
         end
         step();
      end
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      check("ld_req_drop", {31'd0, dmem_req}, 32'd0);
      check("ld_wbv",      {31'd0, wb_valid}, 32'd1);
      check("ld_data",     wb_data,           32'hDEAD_BEEF);
      check("ld_we_wb",    {31'd0, wb_we},    32'd1);
      check("ld_rd",       {29'd0, wb_rd},    32'd2);
      check("ld_ready",    {31'd0, in_ready}, 32'd1);
      step();
      check("ld_pulse_end", {31'd0, wb_valid}, 32'd0);

      // store with ack in first request cycle
      in_valid   = 1'b1;
      mem_write  = 1'b1;
      reg_write  = 1'b1;
      rd         = 3'd4;
      alu_result = 32'h0000_0100;
      store_data = 32'h0000_0055;
      step();
      clear_inputs();
      check("st_req",   {31'd0, dmem_req},  32'd1);
      check("st_we",    {31'd0, dmem_we},   32'd1);
      check("st_wdata", dmem_wdata,         32'h0000_0055);
      check("st_addr",  {16'd0, dmem_addr}, 32'h0000_0100);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      check("st_wbv",   {31'd0, wb_valid}, 32'd1);
      check("st_wbwe",  {31'd0, wb_we},    32'd0);
      check("st_req_0", {31'd0, dmem_req}, 32'd0);
      check("st_err",   {31'd0, bus_err},  32'd0);

      // load timeout: count cycles with request high
      in_valid   = 1'b1;
      mem_read   = 1'b1;
      reg_write  = 1'b1;
      rd         = 3'd6;
      alu_result = 32'h0000_0020;
      step();
      clear_inputs();
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (!dmem_req) break;
         n++;
         step();
      end
      check("to_req_cycles", n,                   32'd15);
      check("to_req_drop",   {31'd0, dmem_req},   32'd0);
      check("to_wbv",        {31'd0, wb_valid},   32'd1);
      check("to_wbwe",       {31'd0, wb_we},      32'd0);
      check("to_err",        {31'd0, bus_err},    32'd1);
      step();
      step();
      check("to_err_sticky", {31'd0, bus_err}, 32'd1);
      in_valid   = 1'b1;
      reg_write  = 1'b1;
      rd         = 3'd1;
      alu_result = 32'h0000_0abc;
      step();
      clear_inputs();
      check("to_err_after_op", {31'd0, bus_err}, 32'd1);
      check("to_alu_after_op", wb_data,          32'h0000_0abc);

      // reset clears the sticky error
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_clears_err", {31'd0, bus_err}, 32'd0);

      // illegal: both read and write
      in_valid   = 1'b1;
      mem_read   = 1'b1;
      mem_write  = 1'b1;
      reg_write  = 1'b1;
      branch     = 1'b1;
      alu_zero   = 1'b1;
      rd         = 3'd1;
      alu_result = 32'h0000_0009;
      step();
      clear_inputs();
      check("ill_req",   {31'd0, dmem_req},     32'd0);
      check("ill_wbv",   {31'd0, wb_valid},     32'd1);
      check("ill_wbwe",  {31'd0, wb_we},        32'd0);
      check("ill_err",   {31'd0, bus_err},      32'd1);
      check("ill_taken", {31'd0, branch_taken}, 32'd0);
      step();
      check("ill_req_later", {31'd0, dmem_req}, 32'd0);

      // reset in the middle of a pending load
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid   = 1'b1;
      mem_read   = 1'b1;
      reg_write  = 1'b1;
      rd         = 3'd5;
      alu_result = 32'h0000_1111;
      step();
      clear_inputs();
      check("mid_req_up", {31'd0, dmem_req}, 32'd1);
      step();
      rst = 1'b1;
      step();
      check_all_zero("mid_rst");
      rst = 1'b0;
      #1;
      check("mid_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("mid_no_wb",  {31'd0, wb_valid}, 32'd0);
      check("mid_no_req", {31'd0, dmem_req}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Execute-to-writeback stage that consumes each ALU result and its zero flag and either forwards it for register writeback or uses it as a data-memory address for a load/store. Runs a small request/acknowledge FSM against a variable-latency data memory with timeout. Resolves branch outcome from the zero flag. Sits directly downstream of the ALU and upstream of the register file write port.

## Interface
Parameters:
- DATA_W, 32, datapath width (matches ALU result)
- ADDR_W, 16, data-memory address width; taken from alu_result[ADDR_W-1:0]
- REG_W, 3, destination register index width
- WAIT_MAX, 15, maximum cycles waiting for dmem_ack before timeout

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept an op
- alu_result  in  DATA_W  ALU result (data or address)
- alu_zero  in  1  ALU zero flag
- store_data  in  DATA_W  data for stores
- mem_read  in  1  op is a load
- mem_write  in  1  op is a store
- reg_write  in  1  op writes rd
- branch  in  1  op is a branch-if-zero
- rd  in  REG_W  destination register
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  memory address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  memory completes request
- wb_valid  out  1  one-cycle writeback pulse
- wb_we  out  1  register write enable (qualified by wb_valid)
- wb_rd  out  REG_W  writeback register
- wb_data  out  DATA_W  writeback data
- branch_taken  out  1  branch & alu_zero, valid with wb_valid
- bus_err  out  1  sticky error flag

## Operation
- States: IDLE, BUSY. in_ready = (state==IDLE) & ~rst. Accept = in_valid & in_ready.
- Accept, no memory op: next cycle wb_valid=1, wb_data=alu_result, wb_we=reg_write, branch_taken=branch&alu_zero; stay IDLE.
- Accept, load or store (exactly one of mem_read/mem_write): go BUSY; next cycle dmem_req=1, dmem_we=mem_write, dmem_addr=alu_result[ADDR_W-1:0], dmem_wdata=store_data; rd/reg_write/mem_read latched. Upper address bits ignored.
- BUSY, dmem_ack sampled high: dmem_req=0 next cycle; wb_valid=1, wb_data = load ? dmem_rdata : alu_result (latched), wb_we = load & latched reg_write; return IDLE. Stores never write a register.
- BUSY timeout: WAIT_MAX consecutive cycles with dmem_req high and no ack -> drop dmem_req, bus_err=1, wb_valid pulse with wb_we=0, return IDLE.
- mem_read & mem_write both set at accept: illegal; no request, bus_err=1, wb_valid pulse with wb_we=0, branch_taken=0.
- rd==0: wb_we forced 0 (register 0 hardwired zero).
- bus_err sticky; cleared only by rst.
- dmem_addr/dmem_wdata/dmem_we stable while dmem_req high.

## Timing
- Reset: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_we, wb_rd, wb_data, branch_taken, bus_err all 0; timer 0.
- Non-memory op: accept cycle N -> wb_valid cycle N+1; throughput 1/cycle.
- Memory op: accept N -> dmem_req high from N+1; ack sampled at cycle M (M>=N+1) -> wb_valid and dmem_req=0 at M+1; in_ready high again at M+1. Minimum latency 2 cycles.
- Timeout: dmem_req high N+1..N+WAIT_MAX; at N+WAIT_MAX+1 dmem_req=0, wb_valid=1, bus_err=1.
- Ack outside BUSY ignored. wb_valid is a single-cycle pulse, never stalls.
- rst mid-BUSY: next cycle dmem_req=0, no wb_valid, state IDLE.

## Structure
- Package mem_stage_pkg: state enum (IDLE, BUSY), default DATA_W/ADDR_W/REG_W constants.
- Sub-module wait_timer: WAIT_MAX counter with clear/enable, output expired; clog2(WAIT_MAX+1) bits.
- Stage FSM, latches and writeback registers in mem_access_stage.

## Test plan
- ALU op: alu_result=0x0000_1234, reg_write=1, rd=3 accepted at N -> wb_valid at N+1, wb_data=0x1234, wb_we=1, wb_rd=3; back-to-back ops each produce wb one cycle later.
- Load, ack after 3 cycles: alu_result=0xABCD_0040, dmem_rdata=0xDEAD_BEEF -> dmem_addr=0x0040, dmem_we=0, req held 3 cycles, wb_data=0xDEADBEEF one cycle after ack, in_ready 0 throughout.
- Store with same-cycle ack: store_data=0x55, ack at N+1 -> dmem_we=1, dmem_wdata=0x55, wb_valid at N+2 with wb_we=0.
- Branch: branch=1, alu_zero=1 -> branch_taken=1 with wb_valid; alu_zero=0 -> branch_taken=0; rd=0 with reg_write=1 -> wb_we=0.
- Timeout: load, ack never asserted, WAIT_MAX=15 -> req drops after 15 cycles, bus_err=1 sticky, wb_we=0; illegal mem_read&mem_write -> no dmem_req, bus_err=1.
- Reset during BUSY -> dmem_req 0 next cycle, no wb_valid, all outputs 0, in_ready 1 after rst deasserts.
